// File: rtl/byte_encode_stream.sv
// Streaming ByteEncode_d packer. It takes NUM_COEFFS coefficients, one per
// handshake, and emits the packed bit string one byte per handshake, LSB first.
// The width d is latched at start, so one instance serves every pk/ct path.
module byte_encode_stream #(
  parameter int NUM_COEFFS = 256,
  parameter int COEFF_W    = 16,
  parameter int Q          = 3329
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         d_sel,
  output logic               busy,
  output logic               done,
  output logic               err,
  input  logic               coeff_valid,
  output logic               coeff_ready,
  input  logic [COEFF_W-1:0] coeff_data,
  output logic               byte_valid,
  input  logic               byte_ready,
  output logic [7:0]         byte_data,
  output logic               byte_last
);
  localparam int CW = $clog2(NUM_COEFFS + 1);
  localparam int BW = $clog2(NUM_COEFFS * 12 / 8 + 1);
  localparam logic signed [COEFF_W+1:0] QS = (COEFF_W + 2)'(Q);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [3:0]    d_q;
  logic [19:0]   acc;     // holds at most 7 leftover bits plus one 12-bit value
  logic [4:0]    cnt;
  logic [CW-1:0] taken;
  logic [BW-1:0] sent;
  logic [BW-1:0] last_idx;
  logic          d_ok, coeff_hs, byte_hs;
  logic [11:0]   val, mask;
  logic signed [COEFF_W+1:0] xs, xr;
  logic          unused_bits;

  assign d_ok     = (d_sel != 4'd0) && (d_sel <= 4'd12);
  assign coeff_hs = coeff_valid && coeff_ready;
  assign byte_hs  = byte_valid && byte_ready;
  assign last_idx = BW'((NUM_COEFFS / 8) * int'(d_q) - 1);

  // Coefficient mapping: d=12 reduces a value in (-Q, 2Q) into [0, Q); smaller d just masks.
  always_comb begin
    xs = {{2{coeff_data[COEFF_W-1]}}, coeff_data};
    if (xs < 0)        xr = xs + QS;
    else if (xs >= QS) xr = xs - QS;
    else               xr = xs;
    mask = (12'd1 << d_q) - 12'd1;
    val  = (d_q == 4'd12) ? xr[11:0] : (coeff_data[11:0] & mask);
  end
  assign unused_bits = ^xr[COEFF_W+1:12];

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && d_ok) state_nxt = RUN;
      RUN:     if (byte_hs && byte_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs and stream handshake signals
  always_comb begin
    busy        = (state == RUN);
    done        = (state == DONE);
    coeff_ready = (state == RUN) && (cnt < 5'd8) && (taken < CW'(NUM_COEFFS));
    byte_valid  = (state == RUN) && (cnt >= 5'd8);
    byte_last   = byte_valid && (sent == last_idx);
    byte_data   = acc[7:0];
  end

  // Datapath: the accumulator either absorbs a coefficient or drops a byte, never both
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q   <= '0;
      acc   <= '0;
      cnt   <= '0;
      taken <= '0;
      sent  <= '0;
      err   <= 1'b0;
    end else begin
      err <= (state == IDLE) && start && !d_ok;
      if (state == IDLE && start && d_ok) begin
        d_q   <= d_sel;
        acc   <= '0;
        cnt   <= '0;
        taken <= '0;
        sent  <= '0;
      end else if (coeff_hs) begin
        acc   <= acc | (20'(val) << cnt);
        cnt   <= cnt + 5'(d_q);
        taken <= taken + 1'b1;
      end else if (byte_hs) begin
        acc  <= acc >> 8;
        cnt  <= cnt - 5'd8;
        sent <= sent + 1'b1;
      end
    end
  end
endmodule
